// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel width and writer state encoding.
// The VGA display reader imports this package for its addrb math.
package fb_pkg;
    localparam int FB_IMG_W     = 160;
    localparam int FB_IMG_H     = 120;
    localparam int FB_BASE_ADDR = 0;
    localparam int FB_ADDR_W    = 15;
    localparam int FB_PIX_W     = 16;

    typedef logic [1:0] fb_state_t;

    localparam fb_state_t ST_IDLE  = 2'd0;
    localparam fb_state_t ST_ARM   = 2'd1;
    localparam fb_state_t ST_WRITE = 2'd2;
    localparam fb_state_t ST_CLEAR = 2'd3;
endpackage

// File: rtl/fb_writer_sync_edge.sv
// Two-flop synchroniser followed by an edge register.
// edge_o pulses for one clk when the synchronised level becomes ACTIVE.
module sync_edge #(
    parameter logic ACTIVE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= ~ACTIVE;
            sync_q <= ~ACTIVE;
            prev_q <= ~ACTIVE;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign edge_o = (sync_q == ACTIVE) && (prev_q != ACTIVE);
endmodule

// File: rtl/fb_writer.sv
// Album-art framebuffer write master: one image per start, writes aligned to display vsync.
// Optional FB_WRITER_CLEAR_EN adds a CLEAR state that fills the image with i_fill.
module fb_writer
    import fb_pkg::*;
#(
    parameter int   IMG_W     = FB_IMG_W,
    parameter int   IMG_H     = FB_IMG_H,
    parameter int   BASE_ADDR = FB_BASE_ADDR,
    parameter logic VS_ACTIVE = 1'b0,
    parameter int   ADDR_W    = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_vs,
`ifdef FB_WRITER_CLEAR_EN
    input  logic              i_clear,
    input  logic [15:0]       i_fill,
`endif
    input  logic              s_valid,
    input  logic              s_sof,
    input  logic [15:0]       s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] addra,
    output logic [15:0]       dina,
    output logic              wea,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    fb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              sof_seen_q, sof_seen_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [15:0]       dina_q, dina_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] wcnt;
    logic              vs_edge;
`ifdef FB_WRITER_CLEAR_EN
    logic [15:0]       fill_q, fill_d;
`endif

    sync_edge #(.ACTIVE(VS_ACTIVE)) u_vs_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(i_vs),
        .edge_o (vs_edge)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sof_seen_d = sof_seen_q;
        wea_d      = 1'b0;
        addra_d    = addra_q;
        dina_d     = dina_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wcnt       = '0;
`ifdef FB_WRITER_CLEAR_EN
        fill_d     = fill_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FB_WRITER_CLEAR_EN
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    fill_d  = i_fill;
                end else
`endif
                if (i_start) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (vs_edge) begin
                    state_d    = ST_WRITE;
                    cnt_d      = '0;
                    sof_seen_d = 1'b0;
                end
            end
            ST_WRITE: begin
                // Abort takes priority over a beat offered in the same cycle.
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    if (s_sof || sof_seen_q) begin
                        wcnt       = s_sof ? '0 : cnt_q;
                        err_d      = s_sof && sof_seen_q && (cnt_q != '0);
                        sof_seen_d = 1'b1;
                        wea_d      = 1'b1;
                        addra_d    = BASE + wcnt;
                        dina_d     = s_data;
                        cnt_d      = wcnt + ONE;
                        if (wcnt == LAST) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`ifdef FB_WRITER_CLEAR_EN
            ST_CLEAR: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    wea_d   = 1'b1;
                    addra_d = BASE + cnt_q;
                    dina_d  = fill_q;
                    cnt_d   = cnt_q + ONE;
                    if (cnt_q == LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sof_seen_q <= 1'b0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef FB_WRITER_CLEAR_EN
            fill_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sof_seen_q <= sof_seen_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef FB_WRITER_CLEAR_EN
            fill_q     <= fill_d;
`endif
        end
    end

    assign s_ready = (state_q == ST_WRITE);
`ifdef FB_WRITER_CLEAR_EN
    assign o_busy  = (state_q == ST_ARM) || (state_q == ST_WRITE) || (state_q == ST_CLEAR);
`else
    assign o_busy  = (state_q == ST_ARM) || (state_q == ST_WRITE);
`endif
    assign wea     = wea_q;
    assign addra   = addra_q;
    assign dina    = dina_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
endmodule

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Write-side master for the album-art framebuffer BRAM. The VGA display path reads this BRAM through addrb/doutb.
- Accepts a valid/ready 16-bit pixel stream from the song/cover loader and writes one full image per start command into BRAM port A.
- Writes begin only at the start of a display vertical-sync pulse, so a new image never tears mid-scan.

Parameters:
- IMG_W, 160, image width in pixels.
- IMG_H, 120, image height in lines.
- BASE_ADDR, 0, first BRAM word address; BASE_ADDR + IMG_W*IMG_H must be <= 32768.
- VS_ACTIVE, 0, active level of i_vs (640x480 sync is negative).
- ADDR_W, 15, BRAM address width.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous active-high reset.
- i_start  in  1  one-cycle request to load a new image.
- i_abort  in  1  one-cycle request to cancel the load in progress.
- i_vs  in  1  display vertical sync; asynchronous to clk (pixel-clock domain).
- s_valid  in  1  pixel beat valid.
- s_sof  in  1  start-of-frame flag, qualified by s_valid.
- s_data  in  16  pixel word.
- s_ready  out  1  writer accepts a beat.
- addra  out  ADDR_W  BRAM port A address.
- dina  out  16  BRAM port A write data.
- wea  out  1  BRAM port A write enable.
- o_busy  out  1  high in ARM or WRITE.
- o_done  out  1  one-cycle pulse after the last pixel is written.
- o_err  out  1  one-cycle pulse on a stream framing error.

Behaviour:
- Reset: state IDLE; addra=0, dina=0, wea=0, s_ready=0, o_busy=0, o_done=0, o_err=0; pixel counter cleared; vsync synchroniser cleared to the inactive level.
- i_vs passes through a 2-flop synchroniser plus an edge register. "VS edge" means the synchronised level changes from inactive to VS_ACTIVE.
- States: IDLE, ARM, WRITE.
- IDLE: s_ready=0. i_start moves to ARM. i_start in any other state is ignored.
- ARM: s_ready=0, o_busy=1. On a VS edge, move to WRITE with the counter at 0 and sof_seen=0.
- WRITE: s_ready=1, o_busy=1. A beat is accepted when s_valid && s_ready.
- Beats accepted before the first s_sof are discarded; no write, and o_err pulses once per discarded beat.
- A beat with s_sof: sets sof_seen and counter=0, then writes at BASE_ADDR.
- A beat with s_sof after sof_seen and counter != 0: o_err pulses, the counter resyncs to 0, and the beat is written at BASE_ADDR.
- Writes are registered, 1-cycle latency: in the cycle after acceptance, wea=1, addra=BASE_ADDR+counter, dina=s_data. wea is 0 in every other cycle; addra and dina hold their last values.
- Address generation: a running counter incremented by 1 per written beat. No multiplier; x/y are not tracked separately.
- Completion: when the written beat has counter == IMG_W*IMG_H-1, the state returns to IDLE in the same cycle as that write's wea. o_done pulses together with that final wea. s_ready drops the cycle after the last accepted beat.
- i_abort in ARM or WRITE: returns to IDLE next cycle with no o_done. A write already registered still completes its single wea cycle. i_abort in IDLE has no effect.
- Simultaneous i_abort and last beat: abort wins; the beat is not written and o_done is not asserted.
- VS edges during WRITE are ignored.
- Asserting rst mid-image forces IDLE immediately. Partially written BRAM contents stay as they are.

Optional Feature:
- Macro FB_WRITER_CLEAR_EN.
- Defined: adds inputs i_clear (1) and i_fill (16), and a state CLEAR. i_clear in IDLE enters CLEAR, with s_ready=0 and o_busy=1. CLEAR writes i_fill (sampled at entry) to every address BASE_ADDR..BASE_ADDR+IMG_W*IMG_H-1, one per cycle, with no vsync wait. It then pulses o_done and returns to IDLE. i_abort exits CLEAR. If i_start and i_clear coincide, i_clear wins.
- Not defined: no such ports or state; i_clear does not exist.

Decomposition:
- Shared package (fb_pkg): IMG_W, IMG_H, BASE_ADDR, ADDR_W, pixel word width 16, and the state enum encoding. The VGA display reader uses the same package for its addrb math.
- One sub-module, sync_edge: 2-flop synchroniser plus an edge detector with an active-level parameter, reused for i_vs.

Test Plan (IMG_W=4, IMG_H=2, BASE_ADDR=0x100):
- i_start, then VS edge after 20 cycles, then 8 beats 0xA000..0xA007 with sof on the first beat. Expect wea writes to 0x100..0x107 with the matching data, o_done coincident with the 0x107 write, and o_busy low afterwards.
- i_start with s_valid held high but no VS edge for 1000 cycles. Expect s_ready=0 and wea=0 throughout. After a VS edge, writes proceed.
- In WRITE: 2 beats without sof, then 8 beats with sof on the first. Expect 2 o_err pulses, no writes for the first 2 beats, and the 8 writes at 0x100..0x107.
- Mid-frame re-sof at beat 5 (counter=4), then 8 beats. Expect 1 o_err and the write address back to 0x100. Total writes 4+8; o_done after the 12th write.
- i_abort after 3 writes. Expect IDLE next cycle, no o_done, and at most the one already-registered write after abort. Repeat with rst asserted asynchronously mid-WRITE: all outputs 0 within the same cycle.
- FB_WRITER_CLEAR_EN: i_clear with i_fill=0x0F0F. Expect 8 consecutive wea cycles at 0x100..0x107 with data 0x0F0F, then o_done.
